// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if: serial line and received-byte signals of the UART receiver.
//   uart_rxd           serial input line, idle high
//   uart_rx_data       last correctly received byte
//   uart_rx_done       one-cycle strobe, uart_rx_data updated
//   uart_rx_frame_err  one-cycle strobe, stop bit sampled low
//   uart_rx_busy       high while a frame is being received
//   uart_rx_parity_err one-cycle strobe with done on even-parity error
//                      (only present when UART_RX_PARITY_EN is defined)
// Modports: slave = receiver side, master = line driver / byte consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_if;
   logic       uart_rxd;
   logic [7:0] uart_rx_data;
   logic       uart_rx_done;
   logic       uart_rx_frame_err;
   logic       uart_rx_busy;
`ifdef UART_RX_PARITY_EN
   logic       uart_rx_parity_err;

   modport slave (
      input  uart_rxd,
      output uart_rx_data,
      output uart_rx_done,
      output uart_rx_frame_err,
      output uart_rx_busy,
      output uart_rx_parity_err
   );

   modport master (
      output uart_rxd,
      input  uart_rx_data,
      input  uart_rx_done,
      input  uart_rx_frame_err,
      input  uart_rx_busy,
      input  uart_rx_parity_err
   );
`else
   modport slave (
      input  uart_rxd,
      output uart_rx_data,
      output uart_rx_done,
      output uart_rx_frame_err,
      output uart_rx_busy
   );

   modport master (
      output uart_rxd,
      input  uart_rx_data,
      input  uart_rx_done,
      input  uart_rx_frame_err,
      input  uart_rx_busy
   );
`endif
endinterface

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx: UART receiver, 8N1 LSB first, one centre sample per bit.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 and adds
// uart_rx_parity_err to the interface.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    uart_rx_if.slave (uart_rxd in; data/done/frame_err/busy out)
// Parameters: CLK_FREQ (Hz), UART_BPS (baud).
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned UART_BPS = 115200
) (
   input  logic     clk,
   input  logic     rst_n,
   uart_rx_if.slave bus
);

   localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
   localparam int unsigned HALF_CNT     = BAUD_CNT_MAX / 2;
   localparam int unsigned CNT_W        = 16;
   localparam int unsigned BIT_W        = 4;
   localparam int unsigned DATA_W       = 8;

   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT_MAX - 1);
   localparam logic [CNT_W-1:0] SAMPLE_PT = CNT_W'(HALF_CNT - 1);
   localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t             state, state_nxt;
   logic               rxd_s1, rxd_s2, rxd_s3;
   logic [CNT_W-1:0]   baud_cnt, baud_nxt;
   logic [BIT_W-1:0]   bit_cnt, bit_nxt;
   logic [DATA_W-1:0]  shift_reg, shift_nxt;
   logic [DATA_W-1:0]  data_q, data_nxt;
   logic               done_q, done_nxt;
   logic               ferr_q, ferr_nxt;
   logic               busy_q, busy_nxt;
   logic               fall_c;
   logic               sample_c;
   logic               wrap_c;
`ifdef UART_RX_PARITY_EN
   logic               par_bit_q, par_bit_nxt;
   logic               perr_q, perr_nxt;
`endif

   // Two-stage synchronizer plus a third stage for falling-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_s1 <= 1'b1;
         rxd_s2 <= 1'b1;
         rxd_s3 <= 1'b1;
      end else begin
         rxd_s1 <= bus.uart_rxd;
         rxd_s2 <= rxd_s1;
         rxd_s3 <= rxd_s2;
      end
   end

   assign fall_c   = rxd_s3 & ~rxd_s2;
   assign sample_c = (baud_cnt == SAMPLE_PT);
   assign wrap_c   = (baud_cnt == BAUD_LAST);

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         baud_cnt  <= baud_nxt;
         bit_cnt   <= bit_nxt;
         shift_reg <= shift_nxt;
         data_q    <= data_nxt;
         done_q    <= done_nxt;
         ferr_q    <= ferr_nxt;
         busy_q    <= busy_nxt;
`ifdef UART_RX_PARITY_EN
         par_bit_q <= par_bit_nxt;
         perr_q    <= perr_nxt;
`endif
      end
   end

   // Next-state, counter and output-strobe logic
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt;
      bit_nxt   = bit_cnt;
      shift_nxt = shift_reg;
      data_nxt  = data_q;
      done_nxt  = 1'b0;
      ferr_nxt  = 1'b0;
      busy_nxt  = busy_q;
`ifdef UART_RX_PARITY_EN
      par_bit_nxt = par_bit_q;
      perr_nxt    = 1'b0;
`endif

      // Free-running per-bit counter while a frame is in progress
      if (state != IDLE) begin
         if (wrap_c) begin
            baud_nxt = '0;
            bit_nxt  = bit_cnt + BIT_W'(1);
         end else begin
            baud_nxt = baud_cnt + CNT_W'(1);
         end
      end

      case (state)
         IDLE: begin
            baud_nxt = '0;
            bit_nxt  = '0;
            if (fall_c) begin
               state_nxt = START;
               busy_nxt  = 1'b1;
            end
         end

         START: begin
            // A start bit that is high again at its centre was a glitch
            if (sample_c) begin
               if (rxd_s2) begin
                  state_nxt = IDLE;
                  busy_nxt  = 1'b0;
                  baud_nxt  = '0;
                  bit_nxt   = '0;
               end else begin
                  state_nxt = DATA;
               end
            end
         end

         DATA: begin
            // LSB arrives first, so shift in from the top
            if (sample_c) begin
               shift_nxt = {rxd_s2, shift_reg[DATA_W-1:1]};
               if (bit_cnt == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (sample_c) begin
               par_bit_nxt = rxd_s2;
               state_nxt   = STOP;
            end
         end
`endif

         STOP: begin
            // Leave at mid-stop-bit so a back-to-back start edge is not missed
            if (sample_c) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               baud_nxt  = '0;
               bit_nxt   = '0;
               if (rxd_s2) begin
                  data_nxt = shift_reg;
                  done_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                  perr_nxt = (^shift_reg) ^ par_bit_q;
`endif
               end else begin
                  ferr_nxt = 1'b1;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            baud_nxt  = '0;
            bit_nxt   = '0;
         end
      endcase
   end

   assign bus.uart_rx_data      = data_q;
   assign bus.uart_rx_done      = done_q;
   assign bus.uart_rx_frame_err = ferr_q;
   assign bus.uart_rx_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
   assign bus.uart_rx_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx: self-checking bench for uart_rx. Drives frames with a behavioural
// serial transmitter at nominal and skewed baud rates, keeps a queue of bytes
// that must arrive, and checks strobes, data, busy and done latency.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int unsigned CLK_FREQ = 50000000;
   localparam int unsigned UART_BPS = 115200;
   localparam int BIT_CLKS  = int'(CLK_FREQ / UART_BPS);
   localparam int HALF      = BIT_CLKS / 2;
   localparam int FAST_CLKS = (BIT_CLKS * 100) / 103;
   localparam int SLOW_CLKS = (BIT_CLKS * 100) / 97;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 10 * BIT_CLKS + HALF + 3;
`else
   localparam int LAT = 9 * BIT_CLKS + HALF + 3;
`endif

   logic clk;
   logic rst_n;

   uart_rx_if bus ();

   uart_rx #(
      .CLK_FREQ (CLK_FREQ),
      .UART_BPS (UART_BPS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: collect strobes on the falling edge
   logic [7:0] rx_q[$];
   int done_cnt = 0;
   int ferr_cnt = 0;
   int both_cnt = 0;
   int last_done_cyc = 0;
`ifdef UART_RX_PARITY_EN
   logic last_perr = 1'b0;
   int   perr_alone = 0;
`endif

   always @(negedge clk) begin
      if (bus.uart_rx_done) begin
         rx_q.push_back(bus.uart_rx_data);
         done_cnt++;
         last_done_cyc = cyc;
`ifdef UART_RX_PARITY_EN
         last_perr = bus.uart_rx_parity_err;
`endif
      end
`ifdef UART_RX_PARITY_EN
      if (bus.uart_rx_parity_err && !bus.uart_rx_done) perr_alone++;
`endif
      if (bus.uart_rx_frame_err) ferr_cnt++;
      if (bus.uart_rx_done && bus.uart_rx_frame_err) both_cnt++;
   end

   // Reference model: bytes whose frames carry a good stop bit
   logic [7:0] exp_q[$];
   logic [7:0] last_good = 8'h00;
   int start_cyc = 0;
`ifdef UART_RX_PARITY_EN
   logic par_flip = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
      total++;
      assert (obs >= lo && obs <= hi) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // Compare everything received against the model queue, then drain both
   task automatic chk_rx(input string tag);
      chk({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
         chk({tag, "_byte"}, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
      end
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic line_for(input logic v, input int clks);
      bus.uart_rxd = v;
      repeat (clks) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input int clks, input logic stop_v);
      start_cyc = cyc;
      line_for(1'b0, clks);
      for (int i = 0; i < 8; i++) line_for(b[i], clks);
`ifdef UART_RX_PARITY_EN
      line_for((^b) ^ par_flip, clks);
`endif
      line_for(stop_v, clks);
      if (stop_v) begin
         exp_q.push_back(b);
         last_good = b;
      end
   endtask

   int d0, f0;
   logic [7:0] skew_bytes[3];
   int skew_clks[2];
   logic [7:0] rnd;

   initial begin
      skew_bytes[0] = 8'h00;
      skew_bytes[1] = 8'hFF;
      skew_bytes[2] = 8'h5A;
      skew_clks[0]  = FAST_CLKS;
      skew_clks[1]  = SLOW_CLKS;

      // Reset values
      bus.uart_rxd = 1'b1;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_data", 32'(bus.uart_rx_data), 32'h0);
      chk("rst_done", 32'(bus.uart_rx_done), 32'h0);
      chk("rst_ferr", 32'(bus.uart_rx_frame_err), 32'h0);
      chk("rst_busy", 32'(bus.uart_rx_busy), 32'h0);
      rst_n = 1'b1;
      line_for(1'b1, 10 * BIT_CLKS);

      // Single frame 0x55 with latency check
      d0 = done_cnt; f0 = ferr_cnt;
      send_frame(8'h55, BIT_CLKS, 1'b1);
      line_for(1'b1, BIT_CLKS);
      chk("single_done", 32'(done_cnt - d0), 32'd1);
      chk("single_data", 32'(bus.uart_rx_data), 32'h55);
      chk_range("single_latency", last_done_cyc - start_cyc, LAT - 1, LAT + 1);
      chk("single_ferr", 32'(ferr_cnt - f0), 32'd0);
      chk("single_busy", 32'(bus.uart_rx_busy), 32'd0);
      chk_rx("single");

      // Back-to-back frames with no idle gap
      d0 = done_cnt; f0 = ferr_cnt;
      send_frame(8'hA3, BIT_CLKS, 1'b1);
      send_frame(8'h3C, BIT_CLKS, 1'b1);
      line_for(1'b1, BIT_CLKS);
      chk("b2b_done", 32'(done_cnt - d0), 32'd2);
      chk("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);
      chk_range("b2b_latency", last_done_cyc - start_cyc, LAT - 1, LAT + 1);
      chk_rx("b2b");

      // 100-clock low glitch on idle line
      d0 = done_cnt; f0 = ferr_cnt;
      line_for(1'b0, 100);
      line_for(1'b1, 50);
      chk("glitch_busy_hi", 32'(bus.uart_rx_busy), 32'd1);
      line_for(1'b1, 150);
      chk("glitch_busy_lo", 32'(bus.uart_rx_busy), 32'd0);
      line_for(1'b1, BIT_CLKS);
      chk("glitch_done", 32'(done_cnt - d0), 32'd0);
      chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
      chk("glitch_data", 32'(bus.uart_rx_data), 32'(last_good));

      // Bad stop bit followed by a held-low break
      d0 = done_cnt; f0 = ferr_cnt;
      send_frame(8'h81, BIT_CLKS, 1'b0);
      line_for(1'b0, 2000);
      line_for(1'b1, 2 * BIT_CLKS);
      chk("break_ferr", 32'(ferr_cnt - f0), 32'd1);
      chk("break_done", 32'(done_cnt - d0), 32'd0);
      chk("break_data", 32'(bus.uart_rx_data), 32'(last_good));
      chk("break_busy", 32'(bus.uart_rx_busy), 32'd0);
      chk_rx("break");

      // Reset at data bit 4 of 0xF0, then a fresh 0x0F frame
      line_for(1'b0, BIT_CLKS);
      for (int i = 0; i < 4; i++) line_for(1'b0, BIT_CLKS);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_data", 32'(bus.uart_rx_data), 32'h0);
      chk("midrst_done", 32'(bus.uart_rx_done), 32'h0);
      chk("midrst_ferr", 32'(bus.uart_rx_frame_err), 32'h0);
      chk("midrst_busy", 32'(bus.uart_rx_busy), 32'h0);
      bus.uart_rxd = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      last_good = 8'h00;
      line_for(1'b1, 2 * BIT_CLKS);
      d0 = done_cnt;
      send_frame(8'h0F, BIT_CLKS, 1'b1);
      line_for(1'b1, BIT_CLKS);
      chk("postrst_done", 32'(done_cnt - d0), 32'd1);
      chk("postrst_data", 32'(bus.uart_rx_data), 32'h0F);
      chk_rx("postrst");

      // Baud skew of +3% and -3%
      f0 = ferr_cnt;
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < 3; k++) begin
            send_frame(skew_bytes[k], skew_clks[s], 1'b1);
            line_for(1'b1, BIT_CLKS);
         end
      end
      chk("skew_ferr", 32'(ferr_cnt - f0), 32'd0);
      chk_rx("skew");

      // Random byte after a random idle gap
      rnd = 8'($urandom);
      line_for(1'b1, int'($urandom_range(1, 400)));
      send_frame(rnd, BIT_CLKS, 1'b1);
      line_for(1'b1, BIT_CLKS);
      chk("rand_data", 32'(bus.uart_rx_data), 32'(rnd));
      chk_rx("rand");

`ifdef UART_RX_PARITY_EN
      // Even parity: correct, then flipped
      d0 = done_cnt;
      par_flip = 1'b0;
      send_frame(8'h5A, BIT_CLKS, 1'b1);
      line_for(1'b1, BIT_CLKS);
      chk("par_ok_done", 32'(done_cnt - d0), 32'd1);
      chk("par_ok_perr", 32'(last_perr), 32'd0);
      d0 = done_cnt;
      par_flip = 1'b1;
      send_frame(8'h5A, BIT_CLKS, 1'b1);
      line_for(1'b1, BIT_CLKS);
      par_flip = 1'b0;
      chk("par_bad_done", 32'(done_cnt - d0), 32'd1);
      chk("par_bad_perr", 32'(last_perr), 32'd1);
      chk("par_alone", 32'(perr_alone), 32'd0);
      chk_rx("par");
`endif

      chk("strobe_exclusive", 32'(both_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
